// File: rtl/sys_array_pkg.sv
// Shared definitions for the systolic-array result drain: FSM state
// encoding, fetcher latency default and result element width.
package sys_array_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Edges from the start_comp sampling edge to the out_data update edge.
  function automatic int fetch_lat(input int array_l, input int array_w);
    return array_l + 2 * array_w + 3;
  endfunction

  // Each result element carries a full-precision product sum.
  function automatic int elem_w(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/sys_array_requant.sv
// Combinational requantizer for one result element: signed arithmetic
// right shift by REQ_SHIFT with round-half-up, then saturation to the
// signed DATA_W range.
module sys_array_requant #(
  parameter int DATA_W    = 8,
  parameter int REQ_SHIFT = 0
) (
  input  logic signed [2*DATA_W-1:0] elem_i,
  output logic signed [DATA_W-1:0]   elem_o
);

  localparam int EW  = 2 * DATA_W;
  localparam int SW  = EW + 1;
  localparam int RND = (REQ_SHIFT > 0) ? (1 << (REQ_SHIFT - 1)) : 0;
  localparam logic signed [SW-1:0] SMAX = SW'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [SW-1:0] SMIN = ~SMAX;

  // One guard bit keeps the rounding add from wrapping at the positive limit.
  function automatic logic signed [SW-1:0] round_shift(input logic signed [EW-1:0] x);
    logic signed [SW-1:0] ext;
    ext = SW'(x);
    ext = ext + SW'(RND);
    return ext >>> REQ_SHIFT;
  endfunction

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [SW-1:0] x);
    if (x > SMAX) begin
      return DATA_W'(SMAX);
    end else if (x < SMIN) begin
      return DATA_W'(SMIN);
    end
    return DATA_W'(x);
  endfunction

  // Pure combinational transform, no latency added.
  always_comb begin
    elem_o = saturate(round_shift(elem_i));
  end

endmodule

// File: rtl/sys_array_drain.sv
// Result drain for the systolic-array fetcher: times each computation from
// comp_start, captures the parallel result matrix when it is ready and
// streams it out row-major, one element per valid/ready transfer.
// Optional build macro SYS_DRAIN_REQUANT_EN narrows each element to DATA_W
// bits through sys_array_requant before the output register.
module sys_array_drain
  import sys_array_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ARRAY_W   = 4,
  parameter int ARRAY_L   = 4,
  parameter int FETCH_LAT = fetch_lat(ARRAY_L, ARRAY_W),
  parameter int REQ_SHIFT = 0,
  localparam int EW       = elem_w(DATA_W),
`ifdef SYS_DRAIN_REQUANT_EN
  localparam int OUT_W    = DATA_W
`else
  localparam int OUT_W    = EW
`endif
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            comp_start,
  input  logic                            res_ready,
  input  logic [EW*ARRAY_W*ARRAY_W-1:0]   res_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OUT_W-1:0]                out_data,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done,
  output logic                            overrun
);

  localparam int N     = ARRAY_W * ARRAY_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = (FETCH_LAT > 0) ? $clog2(FETCH_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] LAT      = CNT_W'(FETCH_LAT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic                    shd_act_q, shd_act_d;
  logic [CNT_W-1:0]        shd_cnt_q, shd_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d, idx_nxt;
  logic [N*EW-1:0]         mat_q, mat_d;
  logic signed [OUT_W-1:0] data_p0, data_d;
  logic                    vld_p0, vld_d;
  logic                    last_p0, last_d;
  logic                    done_q, done_d;
  logic                    overrun_q, overrun_d;

  logic                    xfer, final_xfer, shd_exp, sel_cap;
  logic                    capture, load_next;
  logic signed [EW-1:0]    sel_elem;
  logic signed [OUT_W-1:0] elem_out;

  assign xfer       = vld_p0 & out_ready;
  assign final_xfer = xfer & (idx_q == LAST_IDX);
  // A tracked computation is due once its shadow count is spent and the fetcher is ready.
  assign shd_exp    = shd_act_q & (shd_cnt_q == '0) & res_ready;
  // Element 0 of the live fetcher output is loaded on any capture, otherwise the next buffered one.
  assign sel_cap    = (state_q != DRAIN) | (shd_exp & final_xfer);
  assign idx_nxt    = idx_q + 1'b1;
  assign sel_elem   = sel_cap ? res_data[EW-1:0] : mat_q[int'(idx_nxt)*EW +: EW];

`ifdef SYS_DRAIN_REQUANT_EN
  sys_array_requant #(
    .DATA_W    (DATA_W),
    .REQ_SHIFT (REQ_SHIFT)
  ) u_requant (
    .elem_i (sel_elem),
    .elem_o (elem_out)
  );
`else
  logic unused_req_shift;
  assign unused_req_shift = (REQ_SHIFT != 0);
  assign elem_out         = sel_elem;
`endif

  // Next-state logic: computation tracking, capture decision and stream advance.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    shd_act_d  = shd_act_q;
    shd_cnt_d  = shd_cnt_q;
    idx_d      = idx_q;
    mat_d      = mat_q;
    data_d     = data_p0;
    vld_d      = vld_p0;
    last_d     = last_p0;
    done_d     = 1'b0;
    overrun_d  = overrun_q;
    capture    = 1'b0;
    load_next  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (comp_start) begin
          wait_cnt_d = LAT;
          state_d    = WAIT;
        end
      end

      WAIT: begin
        if ((wait_cnt_q == '0) && res_ready) begin
          capture = 1'b1;
          if (comp_start) begin
            shd_act_d = 1'b1;
            shd_cnt_d = LAT;
          end
        end else if (comp_start) begin
          wait_cnt_d = LAT;
        end else if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end

      DRAIN: begin
        // Shadow tracker for a computation started while the drain is busy.
        if (shd_exp) begin
          shd_act_d = 1'b0;
        end else if (shd_act_q && (shd_cnt_q != '0)) begin
          shd_cnt_d = shd_cnt_q - 1'b1;
        end
        if (comp_start) begin
          shd_act_d = 1'b1;
          shd_cnt_d = LAT;
        end

        if (shd_exp && final_xfer) begin
          capture = 1'b1;
        end else begin
          if (shd_exp) begin
            overrun_d = 1'b1;
          end
          if (final_xfer) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
            done_d = 1'b1;
            // A computation still in flight keeps being timed in WAIT.
            if (shd_act_d) begin
              state_d    = WAIT;
              wait_cnt_d = shd_cnt_d;
              shd_act_d  = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else if (xfer) begin
            load_next = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (capture) begin
      mat_d   = res_data;
      idx_d   = '0;
      data_d  = elem_out;
      vld_d   = 1'b1;
      last_d  = (LAST_IDX == '0);
      state_d = DRAIN;
    end else if (load_next) begin
      idx_d  = idx_nxt;
      data_d = elem_out;
      last_d = (idx_nxt == LAST_IDX);
    end
  end

  // ---- stage p0: matrix buffer, control state and registered stream outputs ----
  // All state, including the buffer and output data, clears on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      shd_act_q  <= 1'b0;
      shd_cnt_q  <= '0;
      idx_q      <= '0;
      mat_q      <= '0;
      data_p0    <= '0;
      vld_p0     <= 1'b0;
      last_p0    <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      shd_act_q  <= shd_act_d;
      shd_cnt_q  <= shd_cnt_d;
      idx_q      <= idx_d;
      mat_q      <= mat_d;
      data_p0    <= data_d;
      vld_p0     <= vld_d;
      last_p0    <= last_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign out_valid = vld_p0;
  assign out_data  = data_p0;
  assign out_last  = last_p0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sys_array_drain.sv
// Bench for sys_array_drain: table of element vectors, directed multi-cycle
// sequences and a randomized run against a transaction-level reference model.
module tb_sys_array_drain;

  localparam int DW  = 8;
  localparam int N   = 16;
  localparam int EW  = 2 * DW;
  localparam int LAT = 15;
`ifdef SYS_DRAIN_REQUANT_EN
  localparam int RS = 4;
  localparam int OW = DW;
`else
  localparam int RS = 0;
  localparam int OW = EW;
`endif

  logic            clock      = 1'b0;
  logic            reset_n    = 1'b0;
  logic            comp_start = 1'b0;
  logic            res_ready  = 1'b0;
  logic            out_ready  = 1'b0;
  logic [EW*N-1:0] res_data   = '0;
  logic            out_valid, out_last, busy, done, overrun;
  logic [OW-1:0]   out_data;

  sys_array_drain #(.REQ_SHIFT(RS)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .comp_start (comp_start),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Element transform from first principles: raw passthrough, or signed
  // round-half-up divide by 2^RS followed by clamping to the 8-bit range.
  function automatic logic [OW-1:0] xform(input logic [EW-1:0] e);
`ifdef SYS_DRAIN_REQUANT_EN
    int v;
    v = (int'(e) >= (1 << (EW - 1))) ? int'(e) - (1 << EW) : int'(e);
    v = v + (1 << (RS - 1));
    v = v >>> RS;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return OW'(v);
`else
    return e;
`endif
  endfunction

  typedef struct {
    logic [EW-1:0] elem;
    logic [OW-1:0] exp;
  } vec_t;
  vec_t tab [N];

  // Reference model: one pending computation, the matrix being streamed and flags.
  int            cyc      = 0;
  bit            pend     = 0;
  int            pend_due = 0;
  int            rem      = 0;
  bit            exp_done = 0;
  bit            exp_ovr  = 0;
  logic [EW-1:0] cur [N];

  logic [OW-1:0] got [$];
  int            first_valid = -1;
  int            done_seen   = 0;
  int            done_cyc    = -1;

  task automatic load_mat(input bit rev);
    for (int k = 0; k < N; k++)
      res_data[k*EW +: EW] = rev ? tab[N-1-k].elem : tab[k].elem;
  endtask

  // One clock edge: log a transfer, advance the model, then compare outputs.
  task automatic tick();
    bit xfer, due, cap, stalled;
    logic [OW-1:0] held_d;
    logic held_l;
    stalled = out_valid && !out_ready;
    held_d  = out_data;
    held_l  = out_last;
    if (out_valid && out_ready) got.push_back(out_data);
    @(posedge clock);
    cyc++;
    xfer     = (rem > 0) && out_ready;
    due      = pend && (cyc >= pend_due) && res_ready;
    cap      = due && ((rem == 0) || (xfer && rem == 1));
    exp_done = 0;
    if (due) pend = 0;
    if (due && !cap) exp_ovr = 1;
    if (cap) begin
      for (int k = 0; k < N; k++) cur[k] = res_data[k*EW +: EW];
      rem = N;
    end else if (xfer) begin
      rem--;
      if (rem == 0) exp_done = 1;
    end
    if (comp_start) begin
      pend     = 1;
      pend_due = cyc + LAT + 1;
    end
    #1;
    chk("valid", out_valid, rem > 0);
    if (rem > 0) begin
      chk("data", out_data, xform(cur[N-rem]));
      chk("last", out_last, rem == 1);
    end
    chk("done", done, exp_done);
    chk("overrun", overrun, exp_ovr);
    chk("busy", busy, (rem > 0) || pend);
    if (stalled) begin
      chk("hold_data", out_data, held_d);
      chk("hold_last", out_last, held_l);
    end
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (done) begin
      done_seen++;
      done_cyc = cyc;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_data", out_data, '0);
    pend = 0; rem = 0; exp_ovr = 0; exp_done = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic clear_obs();
    got.delete();
    first_valid = -1;
    done_seen   = 0;
    done_cyc    = -1;
  endtask

  task automatic chk_matrix(input string name, input int base, input bit rev);
    for (int i = 0; i < N; i++)
      chk(name, (base + i < got.size()) ? got[base+i] : 'x, rev ? tab[N-1-i].exp : tab[i].exp);
  endtask

  task automatic run_basic(input string tag);
    int c0;
    load_mat(0);
    res_ready = 1; out_ready = 1;
    clear_obs();
    comp_start = 1; tick(); comp_start = 0;
    c0 = cyc;
    repeat (40) tick();
    chk({tag, "_capture_edge"}, first_valid - c0, 16);
    chk({tag, "_count"}, got.size(), N);
    chk_matrix({tag, "_elem"}, 0, 0);
    chk({tag, "_done_edge"}, done_cyc - c0, 32);
    chk({tag, "_done_pulses"}, done_seen, 1);
  endtask

  initial begin
    int c0;
`ifdef SYS_DRAIN_REQUANT_EN
    tab[0]  = '{16'h7FFF, 8'h7F}; tab[1]  = '{16'h0018, 8'h02};
    tab[2]  = '{16'hFFE8, 8'hFF}; tab[3]  = '{16'h8000, 8'h80};
    tab[4]  = '{16'h0008, 8'h01}; tab[5]  = '{16'h0007, 8'h00};
    tab[6]  = '{16'hFFF8, 8'h00}; tab[7]  = '{16'hFFF7, 8'hFF};
    tab[8]  = '{16'h07F7, 8'h7F}; tab[9]  = '{16'h07F8, 8'h7F};
    tab[10] = '{16'hF800, 8'h80}; tab[11] = '{16'hF808, 8'h81};
    tab[12] = '{16'hF7F0, 8'h80}; tab[13] = '{16'h0000, 8'h00};
    tab[14] = '{16'h0010, 8'h01}; tab[15] = '{16'h0017, 8'h01};
`else
    for (int k = 0; k < N; k++) tab[k] = '{EW'(k + 1), OW'(k + 1)};
`endif

    // Reset state, then a plain capture and full-rate drain.
    do_reset();
    run_basic("basic");

    // Consumer accepting every other cycle.
    load_mat(0);
    clear_obs();
    out_ready = 1;
    comp_start = 1; tick(); comp_start = 0;
    for (int i = 0; i < 70; i++) begin
      out_ready = i[0];
      tick();
    end
    chk("stall_count", got.size(), N);
    chk_matrix("stall_elem", 0, 0);
    chk("stall_done_pulses", done_seen, 1);

    // Second computation dropped while the consumer stalls.
    do_reset();
    load_mat(0);
    clear_obs();
    out_ready = 1;
    comp_start = 1; tick(); comp_start = 0;
    repeat (16) tick();
    repeat (5) tick();
    comp_start = 1; tick(); comp_start = 0;
    out_ready = 0;
    repeat (20) tick();
    chk("ovr_flag", overrun, 1'b1);
    out_ready = 1;
    repeat (20) tick();
    chk("ovr_count", got.size(), N);
    chk_matrix("ovr_elem", 0, 0);

    // Shadow expiry coinciding with the final transfer: back-to-back matrices.
    do_reset();
    load_mat(0);
    clear_obs();
    out_ready = 1;
    comp_start = 1; tick(); comp_start = 0;
    repeat (15) tick();
    comp_start = 1; tick(); comp_start = 0;
    load_mat(1);
    repeat (40) tick();
    chk("b2b_count", got.size(), 2 * N);
    chk_matrix("b2b_first", 0, 0);
    chk_matrix("b2b_second", N, 1);
    chk("b2b_done_pulses", done_seen, 1);
    chk("b2b_overrun", overrun, 1'b0);

    // Reset in the middle of a drain, then a normal run.
    load_mat(0);
    clear_obs();
    out_ready = 1;
    comp_start = 1; tick(); comp_start = 0;
    for (int i = 0; i < 60 && got.size() < 7; i++) tick();
    chk("mid_idx", got.size(), 7);
    do_reset();
    run_basic("after_rst");

    // Fetcher not ready at expiry: hold in WAIT until res_ready rises.
    do_reset();
    res_ready = 0;
    load_mat(1);
    clear_obs();
    out_ready = 1;
    comp_start = 1; tick(); comp_start = 0;
    c0 = cyc;
    repeat (30) tick();
    chk("norr_no_valid", first_valid, -1);
    chk("norr_busy", busy, 1'b1);
    res_ready = 1;
    tick();
    chk("norr_capture_edge", first_valid - c0, 31);
    repeat (20) tick();
    chk_matrix("norr_elem", 0, 1);

    // Randomized traffic against the reference model.
    do_reset();
    res_ready = 1;
    for (int i = 0; i < 3000; i++) begin
      comp_start = ($urandom_range(0, 29) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) res_data[k*EW +: EW] = EW'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
